// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register slave feeding the PWM block.
// SPI pins are synchronized into clk; 16-bit frames {rw, addr[6:0], data[7:0]}.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  // state  | meaning
  // IDLE   | waiting for nCS fall
  // SHIFT  | capturing up to 16 bits on SCLK rises
  // COMMIT | validate frame and write register, one cycle
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_prev, ncs_prev;
  logic                   sync_sclk, sync_copi, sync_ncs;
  logic                   sclk_rise, ncs_fall, ncs_rise;
  logic [15:0]            shift;
  logic [4:0]             count;
  state_t                 state;

  assign sync_sclk = sclk_sync[SYNC_STAGES-1];
  assign sync_copi = copi_sync[SYNC_STAGES-1];
  assign sync_ncs  = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = !sclk_prev && sync_sclk;
  assign ncs_fall  = ncs_prev && !sync_ncs;
  assign ncs_rise  = !ncs_prev && sync_ncs;

  // nCS chain resets low so a select held low through reset never opens a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_prev <= sync_sclk;
      ncs_prev  <= sync_ncs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift           <= 16'h0000;
      count           <= 5'd0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            shift <= 16'h0000;
            count <= 5'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // nCS rise takes priority over a coincident SCLK rise
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise && count < 5'd16) begin
            shift <= {shift[14:0], sync_copi};
            count <= count + 5'd1;
          end
        end
        COMMIT: begin
          if (count == 5'd16 && shift[15] && shift[14:8] <= MAX_A) begin
            case (shift[14:8])
              7'd0:    en_reg_out_7_0  <= shift[7:0];
              7'd1:    en_reg_out_15_8 <= shift[7:0];
              7'd2:    en_reg_pwm_7_0  <= shift[7:0];
              7'd3:    en_reg_pwm_15_8 <= shift[7:0];
              7'd4:    pwm_duty_cycle  <= shift[7:0];
              default: ;
            endcase
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: drives SPI frames bit by bit and checks registers.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  int total = 0;
  int bad   = 0;

  spi_peripheral dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] regs();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bits(input logic [15:0] f, input int first, input int nbits);
    for (int i = first; i < first + nbits; i++) begin
      copi = (i < 16) ? f[15-i] : 1'b1;
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  // Leaves the bench exactly 4 clk after raw nCS rise; caller checks then idles.
  task automatic spi_frame(input logic [15:0] f, input int nbits);
    ncs = 1'b0;
    wait_clk(5);
    clock_bits(f, 0, nbits);
    wait_clk(5);
    ncs = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(20);
    total++;
    if (regs() !== 40'h0) begin
      bad++; $display("FAIL reset_regs got=%h want=%h", regs(), 40'h0);
    end
  endtask

  task automatic test_writes();
    logic [15:0] frames [5] = '{16'h80F0, 16'h81CC, 16'h8255, 16'h83AA, 16'h8480};
    logic [39:0] want [5]   = '{40'hF000000000, 40'hF0CC000000, 40'hF0CC550000,
                                40'hF0CC55AA00, 40'hF0CC55AA80};
    for (int k = 0; k < 5; k++) begin
      spi_frame(frames[k], 16);
      total++;
      if (regs() !== want[k]) begin
        bad++; $display("FAIL write_%h got=%h want=%h", frames[k], regs(), want[k]);
      end
      wait_clk(6);
    end
  endtask

  task automatic test_reject();
    logic [15:0] frames [2] = '{16'h00FF, 16'h85FF};
    for (int k = 0; k < 2; k++) begin
      spi_frame(frames[k], 16);
      wait_clk(6);
      total++;
      if (regs() !== 40'hF0CC55AA80) begin
        bad++; $display("FAIL reject_%h got=%h want=%h", frames[k], regs(), 40'hF0CC55AA80);
      end
    end
  endtask

  task automatic test_short_frame();
    spi_frame(16'h80F0, 15);
    wait_clk(6);
    total++;
    if (regs() !== 40'hF0CC55AA80) begin
      bad++; $display("FAIL short_frame got=%h want=%h", regs(), 40'hF0CC55AA80);
    end
    spi_frame(16'h8011, 16);
    total++;
    if (en_reg_out_7_0 !== 8'h11) begin
      bad++; $display("FAIL after_short got=%h want=%h", en_reg_out_7_0, 8'h11);
    end
    wait_clk(6);
  endtask

  task automatic test_long_frame();
    spi_frame(16'h8233, 18);
    total++;
    if (regs() !== 40'h11CC33AA80) begin
      bad++; $display("FAIL long_frame got=%h want=%h", regs(), 40'h11CC33AA80);
    end
    wait_clk(6);
  endtask

  task automatic test_reset_mid_frame();
    ncs = 1'b0;
    wait_clk(5);
    clock_bits(16'h84FF, 0, 8);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    clock_bits(16'h84FF, 8, 8);
    wait_clk(5);
    ncs = 1'b1;
    wait_clk(10);
    total++;
    if (pwm_duty_cycle !== 8'h00) begin
      bad++; $display("FAIL reset_mid_duty got=%h want=%h", pwm_duty_cycle, 8'h00);
    end
    total++;
    if (regs() !== 40'h0) begin
      bad++; $display("FAIL reset_mid_regs got=%h want=%h", regs(), 40'h0);
    end
    spi_frame(16'h8440, 16);
    total++;
    if (regs() !== 40'h0000000040) begin
      bad++; $display("FAIL after_reset_write got=%h want=%h", regs(), 40'h0000000040);
    end
    wait_clk(6);
  endtask

  initial begin
    test_reset();
    test_writes();
    test_reject();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
